// File: rtl/fifo_uart_tx_pkg.sv
// Shared encodings for the FIFO-fed UART transmitter and its parity helper.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational UART parity generator; shared with the planned RX checker.
module uart_parity_calc
  import fifo_uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par_bit
);

  logic xor_all;

  assign xor_all = ^data;
  assign par_bit = (par_typ == PAR_ODD) ? ~xor_all : xor_all;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a first-word-fall-through FIFO and sends each as a UART frame.
//
// state  | meaning
// IDLE   | line high, waiting for FIFO_EMPTY=0
// LOAD   | one cycle: word and parity settings latched, FIFO_RINC pulsed
// START  | start bit (0) for PRESCALE cycles
// DATA   | WIDTH data bits, LSB first, PRESCALE cycles each
// PARITY | optional parity bit for PRESCALE cycles
// STOP   | stop bit (1); may chain straight into LOAD
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FIFO_EMPTY,
  input  logic [WIDTH-1:0] FIFO_RDATA,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic             FIFO_RINC,
  output logic             TX_OUT,
  output logic             BUSY
);

  localparam int              BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]      PS_LAST  = 8'(PRESCALE - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [7:0]       ps_q, ps_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             par_calc;
  logic             bit_end;
  logic             load;
  logic             tx_d, busy_d, rinc_d;

  // Parity is resolved from the head word at LOAD entry, so later PAR_TYP changes cannot leak in.
  uart_parity_calc #(.WIDTH(WIDTH)) u_parity (
    .data    (FIFO_RDATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    load      = 1'b0;
    bit_end   = (ps_q == PS_LAST);

    if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) begin
      ps_d = bit_end ? 8'd0 : ps_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (!FIFO_EMPTY) load = 1'b1;
      end
      LOAD: begin
        state_d = START;
        ps_d    = 8'd0;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!FIFO_EMPTY) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = LOAD;
      sh_d      = FIFO_RDATA;
      par_en_d  = PAR_EN;
      par_bit_d = par_calc;
      ps_d      = 8'd0;
    end

    // Outputs are decoded from the next state so the line is registered with no extra latency.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    rinc_d = (state_d == LOAD);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      ps_q      <= 8'd0;
      bit_q     <= '0;
      sh_q      <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      FIFO_RINC <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      TX_OUT    <= tx_d;
      BUSY      <= busy_d;
      FIFO_RINC <= rinc_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a queue-backed FWFT FIFO model.
module tb_fifo_uart_tx;

  localparam int W    = 8;
  localparam int PS   = 4;
  localparam int LEN  = 1 + PS * (2 + W);
  localparam int LENP = LEN + PS;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       FIFO_EMPTY = 1'b1;
  logic [7:0] FIFO_RDATA = 8'h00;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       FIFO_RINC, TX_OUT, BUSY;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int pops = 0;
  int bad_pops = 0;
  logic rinc_prev = 1'b0;
  logic [7:0] fifo_q[$];
  logic tx_tr   [0:4095];
  logic busy_tr [0:4095];
  logic rinc_tr [0:4095];

  fifo_uart_tx #(.WIDTH(W), .PRESCALE(PS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RDATA (FIFO_RDATA),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .FIFO_RINC  (FIFO_RINC),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic drive_fifo();
    FIFO_EMPTY = (fifo_q.size() == 0);
    FIFO_RDATA = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // One clock: sample just after the edge, record the trace, apply any pop that edge performed.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc < 4096) begin
      tx_tr[cyc]   = TX_OUT;
      busy_tr[cyc] = BUSY;
      rinc_tr[cyc] = FIFO_RINC;
    end
    if (rinc_prev) begin
      pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (FIFO_RINC === 1'b1 && fifo_q.size() == 0) bad_pops++;
    rinc_prev = FIFO_RINC;
    drive_fifo();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_rinc(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (FIFO_RINC === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Expected line level c cycles after the LOAD cycle of a frame.
  function automatic logic exp_tx(input logic [7:0] w, input logic pe, input logic pb, input int c);
    int slot;
    if (c == 0) return 1'b1;
    slot = (c - 1) / PS;
    if (slot == 0) return 1'b0;
    if (slot <= W) return w[slot-1];
    if (pe && slot == W + 1) return pb;
    return 1'b1;
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    fifo_q.push_back(8'h5A);
    drive_fifo();
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_RINC !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_outputs cycle %0d: tx=%b busy=%b rinc=%b, required tx=1 busy=0 rinc=0",
                 i, TX_OUT, BUSY, FIFO_RINC);
      end
    end
    compared++;
    if (pops !== 0) begin
      mismatched++;
      $display("FAIL reset_no_pop: pops=%0d, required 0", pops);
    end
    fifo_q.delete();
    drive_fifo();
    RST = 1'b1;
    tick();
    compared++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_idle: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, BUSY);
    end
  endtask

  task automatic test_single();
    int n, t;
    PAR_EN = 1'b0;
    fifo_q.push_back(8'hA5);
    drive_fifo();
    n = cyc;
    wait_rinc(10, t);
    compared++;
    if (t != n + 1) begin
      mismatched++;
      $display("FAIL single_rinc_cycle: got %0d, required %0d", t, n + 1);
    end
    if (t < 0) return;
    ticks(LEN);
    for (int c = 0; c < LEN; c++) begin
      compared++;
      if (tx_tr[t+c] !== exp_tx(8'hA5, 1'b0, 1'b0, c) || busy_tr[t+c] !== 1'b1 ||
          rinc_tr[t+c] !== (c == 0)) begin
        mismatched++;
        $display("FAIL single_frame c=%0d: tx=%b busy=%b rinc=%b, required tx=%b busy=1 rinc=%b",
                 c, tx_tr[t+c], busy_tr[t+c], rinc_tr[t+c], exp_tx(8'hA5, 1'b0, 1'b0, c), (c == 0));
      end
    end
    compared++;
    if (busy_tr[t+LEN] !== 1'b0 || tx_tr[t+LEN] !== 1'b1) begin
      mismatched++;
      $display("FAIL single_end: busy=%b tx=%b, required busy=0 tx=1", busy_tr[t+LEN], tx_tr[t+LEN]);
    end
  endtask

  task automatic test_parity();
    logic [7:0] words [0:2];
    logic       typs  [0:2];
    logic       pbits [0:2];
    int n, t;
    words = '{8'hA5, 8'hA5, 8'h07};
    typs  = '{1'b0, 1'b1, 1'b0};
    pbits = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      PAR_EN  = 1'b1;
      PAR_TYP = typs[k];
      fifo_q.push_back(words[k]);
      drive_fifo();
      n = cyc;
      wait_rinc(10, t);
      compared++;
      if (t != n + 1) begin
        mismatched++;
        $display("FAIL parity_rinc_cycle vec %0d: got %0d, required %0d", k, t, n + 1);
      end
      if (t < 0) return;
      ticks(LENP);
      compared++;
      if (tx_tr[t+1+PS*(W+1)] !== pbits[k]) begin
        mismatched++;
        $display("FAIL parity_bit vec %0d: got %b, required %b", k, tx_tr[t+1+PS*(W+1)], pbits[k]);
      end
      for (int c = 0; c < LENP; c++) begin
        compared++;
        if (tx_tr[t+c] !== exp_tx(words[k], 1'b1, pbits[k], c) || busy_tr[t+c] !== 1'b1) begin
          mismatched++;
          $display("FAIL parity_frame vec %0d c=%0d: tx=%b busy=%b, required tx=%b busy=1",
                   k, c, tx_tr[t+c], busy_tr[t+c], exp_tx(words[k], 1'b1, pbits[k], c));
        end
      end
      compared++;
      if (busy_tr[t+LENP] !== 1'b0) begin
        mismatched++;
        $display("FAIL parity_len vec %0d: busy=%b after %0d cycles, required 0", k, busy_tr[t+LENP], LENP);
      end
    end
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1, wexp, rx;
    int n, t, cnt, base;
    w0 = 8'h01;
    w1 = 8'h80;
    PAR_EN = 1'b0;
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    drive_fifo();
    n = cyc;
    wait_rinc(10, t);
    compared++;
    if (t != n + 1) begin
      mismatched++;
      $display("FAIL b2b_rinc_cycle: got %0d, required %0d", t, n + 1);
    end
    if (t < 0) return;
    ticks(2 * LEN);
    cnt = 0;
    for (int c = 0; c <= 2 * LEN; c++) if (rinc_tr[t+c] === 1'b1) cnt++;
    compared++;
    if (cnt != 2 || rinc_tr[t+LEN] !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_rinc_spacing: pulses=%0d second=%b, required pulses=2 second=1", cnt, rinc_tr[t+LEN]);
    end
    for (int c = 0; c < 2 * LEN; c++) begin
      wexp = (c < LEN) ? w0 : w1;
      compared++;
      if (tx_tr[t+c] !== exp_tx(wexp, 1'b0, 1'b0, c % LEN) || busy_tr[t+c] !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_frame c=%0d: tx=%b busy=%b, required tx=%b busy=1",
                 c, tx_tr[t+c], busy_tr[t+c], exp_tx(wexp, 1'b0, 1'b0, c % LEN));
      end
    end
    compared++;
    if (busy_tr[t+2*LEN] !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_end: busy=%b, required 0", busy_tr[t+2*LEN]);
    end
    for (int k = 0; k < 2; k++) begin
      base = t + k * LEN;
      wexp = (k == 0) ? w0 : w1;
      for (int i = 0; i < W; i++) rx[i] = tx_tr[base+1+PS*(1+i)+PS/2];
      compared++;
      if (tx_tr[base+1+PS/2] !== 1'b0 || rx !== wexp) begin
        mismatched++;
        $display("FAIL b2b_rx_byte %0d: start=%b byte=%h, required start=0 byte=%h",
                 k, tx_tr[base+1+PS/2], rx, wexp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, t, p0;
    PAR_EN = 1'b0;
    p0 = pops;
    fifo_q.push_back(8'h3C);
    drive_fifo();
    n = cyc;
    wait_rinc(10, t);
    compared++;
    if (t != n + 1) begin
      mismatched++;
      $display("FAIL rstmid_rinc_cycle: got %0d, required %0d", t, n + 1);
    end
    if (t < 0) return;
    ticks(18);
    compared++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_in_bit3: tx=%b busy=%b, required tx=1 busy=1", TX_OUT, BUSY);
    end
    RST = 1'b0;
    tick();
    compared++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_RINC !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_forced: tx=%b busy=%b rinc=%b, required tx=1 busy=0 rinc=0", TX_OUT, BUSY, FIFO_RINC);
    end
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      compared++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_RINC !== 1'b0) begin
        mismatched++;
        $display("FAIL rstmid_idle cycle %0d: tx=%b busy=%b rinc=%b, required tx=1 busy=0 rinc=0",
                 i, TX_OUT, BUSY, FIFO_RINC);
      end
    end
    compared++;
    if (pops != p0 + 1) begin
      mismatched++;
      $display("FAIL rstmid_pops: got %0d, required %0d", pops - p0, 1);
    end
  endtask

  task automatic test_mid_change();
    int n, t, t2;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    fifo_q.push_back(8'h55);
    drive_fifo();
    n = cyc;
    wait_rinc(10, t);
    compared++;
    if (t != n + 1) begin
      mismatched++;
      $display("FAIL midchg_rinc_cycle: got %0d, required %0d", t, n + 1);
    end
    if (t < 0) return;
    ticks(10);
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b1;
    fifo_q.push_back(8'h0F);
    drive_fifo();
    ticks(LEN + LENP);
    t2 = t + LEN;
    for (int c = 0; c < LEN; c++) begin
      compared++;
      if (tx_tr[t+c] !== exp_tx(8'h55, 1'b0, 1'b0, c)) begin
        mismatched++;
        $display("FAIL midchg_frame1 c=%0d: tx=%b, required %b", c, tx_tr[t+c], exp_tx(8'h55, 1'b0, 1'b0, c));
      end
    end
    compared++;
    if (rinc_tr[t2] !== 1'b1) begin
      mismatched++;
      $display("FAIL midchg_frame1_len: second pop at +%0d is %b, required 1", LEN, rinc_tr[t2]);
    end
    for (int c = 0; c < LENP; c++) begin
      compared++;
      if (tx_tr[t2+c] !== exp_tx(8'h0F, 1'b1, 1'b1, c) || busy_tr[t2+c] !== 1'b1) begin
        mismatched++;
        $display("FAIL midchg_frame2 c=%0d: tx=%b busy=%b, required tx=%b busy=1",
                 c, tx_tr[t2+c], busy_tr[t2+c], exp_tx(8'h0F, 1'b1, 1'b1, c));
      end
    end
    compared++;
    if (busy_tr[t2+LENP] !== 1'b0) begin
      mismatched++;
      $display("FAIL midchg_frame2_len: busy=%b, required 0", busy_tr[t2+LENP]);
    end
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_mid_change();
    compared++;
    if (bad_pops != 0) begin
      mismatched++;
      $display("FAIL pop_when_empty: got %0d, required 0", bad_pops);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
